// File: rtl/sha256_msg_padder.sv
// -----------------------------------------------------------------------------
// sha256_msg_padder
//
// Upstream feeder for the SHA-256 compression stage. On start it reads
// NUM_OF_WORDS raw 32-bit message words from a shared word-addressed memory,
// appends SHA-256 padding (0x80000000 marker, zero fill, 64-bit bit length)
// and streams the padded message, one word per handshake, as whole 16-word
// (512-bit) blocks.
//
// Ports:
//   clk             single clock, rising-edge active
//   reset_n         asynchronous active-low reset
//   start           begin a message (only looked at while idle)
//   message_addr    word address of message word 0, captured with start
//   done            high while idle / finished
//   mem_clk         memory clock (same as clk)
//   mem_we          memory write enable, tied low (read-only client)
//   mem_addr        registered memory read address
//   mem_read_data   memory read data, valid one clk after mem_addr
//   out_valid       out_data holds a padded word
//   out_ready       consumer takes the word when out_valid && out_ready
//   out_data        padded message word
//   out_word_idx    position of the word inside its block (0..15)
//   out_last_block  word belongs to the final block
// -----------------------------------------------------------------------------
module sha256_msg_padder #(
    parameter int NUM_OF_WORDS = 20
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] message_addr,
    output logic        done,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    input  logic [31:0] mem_read_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [3:0]  out_word_idx,
    output logic        out_last_block
);

    // Message of N words needs N + 1 (marker) + 2 (length) words, rounded up
    // to whole 16-word blocks.
    localparam int NB    = (NUM_OF_WORDS + 3 + 15) / 16;
    localparam int TOTAL = 16 * NB;
    localparam int K_W   = $clog2(TOTAL);

    localparam logic [63:0]    LEN        = 64'(NUM_OF_WORDS) * 64'd32;
    localparam logic [K_W-1:0] K_MSG_END  = K_W'(NUM_OF_WORDS);
    localparam logic [K_W-1:0] K_LEN_HI   = K_W'(TOTAL - 2);
    localparam logic [K_W-1:0] K_LEN_LO   = K_W'(TOTAL - 1);
    localparam logic [K_W-1:0] K_LAST_BLK = K_W'(TOTAL - 16);
    localparam logic [K_W-1:0] K_ONE      = K_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_REQ  = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_EMIT    = 2'd3
    } state_t;

    state_t         state_q,          state_d;
    logic [K_W-1:0] k_q,              k_d;
    logic [15:0]    base_q,           base_d;
    logic           wait_q,           wait_d;
    logic [15:0]    mem_addr_q,       mem_addr_d;
    logic           out_valid_q,      out_valid_d;
    logic [31:0]    out_data_q,       out_data_d;
    logic [3:0]     out_word_idx_q,   out_word_idx_d;
    logic           out_last_block_q, out_last_block_d;
    logic           done_q,           done_d;

    // Value of a padding word (any k at or beyond the end of the message).
    function automatic logic [31:0] pad_word(input logic [K_W-1:0] k);
        logic [31:0] w;
        if (k == K_MSG_END) begin
            w = 32'h8000_0000;
        end else if (k == K_LEN_HI) begin
            w = LEN[63:32];
        end else if (k == K_LEN_LO) begin
            w = LEN[31:0];
        end else begin
            w = 32'h0000_0000;
        end
        return w;
    endfunction

    // Next-state and next-output computation for the padding FSM.
    always_comb begin
        state_d          = state_q;
        k_d              = k_q;
        base_d           = base_q;
        wait_d           = wait_q;
        mem_addr_d       = mem_addr_q;
        out_valid_d      = out_valid_q;
        out_data_d       = out_data_q;
        out_word_idx_d   = out_word_idx_q;
        out_last_block_d = out_last_block_q;
        done_d           = done_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d  = message_addr;
                    k_d     = '0;
                    state_d = ST_RD_REQ;
                    done_d  = 1'b0;
                end else begin
                    done_d  = 1'b1;
                end
            end

            ST_RD_REQ: begin
                // Side-band travels with the word so it is stable in EMIT.
                out_word_idx_d   = k_q[3:0];
                out_last_block_d = (k_q >= K_LAST_BLK);
                if (k_q < K_MSG_END) begin
                    // 16-bit address arithmetic wraps modulo 2^16 on purpose.
                    mem_addr_d = base_q + 16'(k_q);
                    wait_d     = 1'b0;
                    state_d    = ST_RD_WAIT;
                end else begin
                    out_data_d  = pad_word(k_q);
                    out_valid_d = 1'b1;
                    state_d     = ST_EMIT;
                end
            end

            ST_RD_WAIT: begin
                // First edge lets the synchronous memory register its output;
                // the second edge captures it.
                if (!wait_q) begin
                    wait_d = 1'b1;
                end else begin
                    wait_d      = 1'b0;
                    out_data_d  = mem_read_data;
                    out_valid_d = 1'b1;
                    state_d     = ST_EMIT;
                end
            end

            ST_EMIT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (k_q == K_LEN_LO) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        k_d     = k_q + K_ONE;
                        state_d = ST_RD_REQ;
                    end
                end else begin
                    out_valid_d = 1'b1;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
                done_d      = 1'b1;
            end
        endcase
    end

    // State and output registers; reset aborts any message in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= ST_IDLE;
            k_q              <= '0;
            base_q           <= 16'h0000;
            wait_q           <= 1'b0;
            mem_addr_q       <= 16'h0000;
            out_valid_q      <= 1'b0;
            out_data_q       <= 32'h0000_0000;
            out_word_idx_q   <= 4'h0;
            out_last_block_q <= 1'b0;
            done_q           <= 1'b1;
        end else begin
            state_q          <= state_d;
            k_q              <= k_d;
            base_q           <= base_d;
            wait_q           <= wait_d;
            mem_addr_q       <= mem_addr_d;
            out_valid_q      <= out_valid_d;
            out_data_q       <= out_data_d;
            out_word_idx_q   <= out_word_idx_d;
            out_last_block_q <= out_last_block_d;
            done_q           <= done_d;
        end
    end

    assign mem_clk        = clk;
    assign mem_we         = 1'b0;
    assign mem_addr       = mem_addr_q;
    assign out_valid      = out_valid_q;
    assign out_data       = out_data_q;
    assign out_word_idx   = out_word_idx_q;
    assign out_last_block = out_last_block_q;
    assign done           = done_q;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// -----------------------------------------------------------------------------
// Self-checking bench for sha256_msg_padder. Three instances (20, 13 and 14
// message words) share a clock, reset and a synchronous-read memory model.
// Expected padded words and read addresses are pushed to queues when a
// message is started and popped as the DUT hands words over.
// -----------------------------------------------------------------------------
module tb_sha256_msg_padder;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  idx;
        logic        last;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic [2:0]  start_v;
    logic [2:0]  ready_v;
    logic [15:0] base_v      [3];
    logic [2:0]  done_w;
    logic [2:0]  mem_clk_w;
    logic [2:0]  mem_we_w;
    logic [15:0] mem_addr_w  [3];
    logic [31:0] rdata_w     [3];
    logic [2:0]  out_valid_w;
    logic [31:0] out_data_w  [3];
    logic [3:0]  idx_w       [3];
    logic [2:0]  out_last_w;

    logic [31:0] mem [0:65535];

    exp_t        exp_q  [$];
    logic [15:0] addr_q [$];

    int checks_total;
    int checks_passed;
    bit we_bad;

    sha256_msg_padder #(.NUM_OF_WORDS(20)) dut20 (
        .clk(clk), .reset_n(reset_n), .start(start_v[0]), .message_addr(base_v[0]),
        .done(done_w[0]), .mem_clk(mem_clk_w[0]), .mem_we(mem_we_w[0]),
        .mem_addr(mem_addr_w[0]), .mem_read_data(rdata_w[0]),
        .out_valid(out_valid_w[0]), .out_ready(ready_v[0]), .out_data(out_data_w[0]),
        .out_word_idx(idx_w[0]), .out_last_block(out_last_w[0])
    );

    sha256_msg_padder #(.NUM_OF_WORDS(13)) dut13 (
        .clk(clk), .reset_n(reset_n), .start(start_v[1]), .message_addr(base_v[1]),
        .done(done_w[1]), .mem_clk(mem_clk_w[1]), .mem_we(mem_we_w[1]),
        .mem_addr(mem_addr_w[1]), .mem_read_data(rdata_w[1]),
        .out_valid(out_valid_w[1]), .out_ready(ready_v[1]), .out_data(out_data_w[1]),
        .out_word_idx(idx_w[1]), .out_last_block(out_last_w[1])
    );

    sha256_msg_padder #(.NUM_OF_WORDS(14)) dut14 (
        .clk(clk), .reset_n(reset_n), .start(start_v[2]), .message_addr(base_v[2]),
        .done(done_w[2]), .mem_clk(mem_clk_w[2]), .mem_we(mem_we_w[2]),
        .mem_addr(mem_addr_w[2]), .mem_read_data(rdata_w[2]),
        .out_valid(out_valid_w[2]), .out_ready(ready_v[2]), .out_data(out_data_w[2]),
        .out_word_idx(idx_w[2]), .out_last_block(out_last_w[2])
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memory: data appears one clk after the address.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            rdata_w[i] <= mem[mem_addr_w[i]];
        end
    end

    function automatic int inst_words(input int inst);
        int n;
        case (inst)
            0:       n = 20;
            1:       n = 13;
            2:       n = 14;
            default: n = 20;
        endcase
        return n;
    endfunction

    // Reference padding model: fills the expected word and address queues.
    task automatic push_expected(input int n, input logic [15:0] base);
        int   total;
        exp_t e;
        total = ((n + 18) / 16) * 16;
        for (int k = 0; k < total; k++) begin
            if (k < n) begin
                e.data = mem[16'(base + k)];
                addr_q.push_back(16'(base + k));
            end else if (k == n) begin
                e.data = 32'h8000_0000;
            end else if (k == total - 1) begin
                e.data = 32'(n * 32);
            end else begin
                e.data = 32'h0000_0000;
            end
            e.idx  = 4'(k % 16);
            e.last = (k >= total - 16);
            exp_q.push_back(e);
        end
    endtask

    // Pulse start for one edge and confirm done dropped.
    task automatic start_msg(input int inst, input logic [15:0] base);
        base_v[inst] = base;
        push_expected(inst_words(inst), base);
        @(negedge clk);
        start_v[inst] = 1'b1;
        @(negedge clk);
        start_v[inst] = 1'b0;
        checks_total++;
        if (done_w[inst] !== 1'b0) begin
            $display("FAIL done_fall inst%0d: got %b want 0", inst, done_w[inst]);
        end else begin
            checks_passed++;
        end
    endtask

    // Drive out_ready (with optional random stalls) and score each accepted word.
    task automatic run_stream(input int inst, input int max_stall, input bit chk_addr,
                              input int stop_after, output int first_iter);
        int          iter;
        int          accepted;
        int          stall_left;
        bit          held;
        bit          fin;
        logic [31:0] h_data;
        logic [3:0]  h_idx;
        logic        h_last;
        logic [15:0] prev_addr;
        logic [15:0] exp_a;
        exp_t        e;
        iter = 0; accepted = 0; stall_left = 0; held = 0; fin = 0;
        first_iter = -1;
        h_data = 32'h0; h_idx = 4'h0; h_last = 1'b0;
        prev_addr = mem_addr_w[inst];
        while (!fin && iter < 2000) begin
            @(negedge clk);
            iter++;
            if (mem_we_w[inst] !== 1'b0) we_bad = 1'b1;
            if (chk_addr && mem_addr_w[inst] !== prev_addr) begin
                prev_addr = mem_addr_w[inst];
                checks_total++;
                if (addr_q.size() == 0) begin
                    $display("FAIL rd_addr inst%0d: got %h want no read", inst, prev_addr);
                end else begin
                    exp_a = addr_q.pop_front();
                    if (prev_addr !== exp_a) begin
                        $display("FAIL rd_addr inst%0d: got %h want %h", inst, prev_addr, exp_a);
                    end else begin
                        checks_passed++;
                    end
                end
            end
            if (out_valid_w[inst] === 1'b1) begin
                if (first_iter < 0) first_iter = iter;
                if (held) begin
                    checks_total++;
                    if ({out_data_w[inst], idx_w[inst], out_last_w[inst]} !== {h_data, h_idx, h_last}) begin
                        $display("FAIL stall_stable inst%0d: got %h/%0d/%b want %h/%0d/%b", inst,
                                 out_data_w[inst], idx_w[inst], out_last_w[inst], h_data, h_idx, h_last);
                    end else begin
                        checks_passed++;
                    end
                end
                if (stall_left > 0) begin
                    ready_v[inst] = 1'b0;
                    stall_left--;
                end else begin
                    ready_v[inst] = 1'b1;
                end
                if (ready_v[inst]) begin
                    held = 1'b0;
                    accepted++;
                    checks_total++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL extra_word inst%0d: got %h want none", inst, out_data_w[inst]);
                        fin = 1'b1;
                    end else begin
                        e = exp_q.pop_front();
                        if ({out_data_w[inst], idx_w[inst], out_last_w[inst]} !== {e.data, e.idx, e.last}) begin
                            $display("FAIL word%0d inst%0d: got %h/%0d/%b want %h/%0d/%b", accepted - 1, inst,
                                     out_data_w[inst], idx_w[inst], out_last_w[inst], e.data, e.idx, e.last);
                        end else begin
                            checks_passed++;
                        end
                    end
                    stall_left = (max_stall > 0) ? int'($urandom_range(max_stall, 0)) : 0;
                    if (exp_q.size() == 0 || (stop_after > 0 && accepted == stop_after)) fin = 1'b1;
                end else begin
                    held   = 1'b1;
                    h_data = out_data_w[inst];
                    h_idx  = idx_w[inst];
                    h_last = out_last_w[inst];
                end
            end else begin
                if (held) begin
                    checks_total++;
                    $display("FAIL valid_drop inst%0d: got 0 want 1", inst);
                    held = 1'b0;
                end
                // Ready toggles freely while nothing is offered.
                ready_v[inst] = (max_stall > 0) ? ($urandom_range(1, 0) == 1) : 1'b1;
            end
        end
        if (!fin) begin
            checks_total++;
            $display("FAIL stream_timeout inst%0d: got %0d words want %0d more", inst, accepted, exp_q.size());
        end
        @(negedge clk);
        ready_v[inst] = 1'b0;
        if (stop_after == 0) begin
            checks_total++;
            if ({done_w[inst], out_valid_w[inst]} !== 2'b10) begin
                $display("FAIL end_state inst%0d: got done/valid %b%b want 10", inst, done_w[inst], out_valid_w[inst]);
            end else begin
                checks_passed++;
            end
        end
    endtask

    task automatic check_idle_reset(input string tag);
        checks_total++;
        if ({out_valid_w[0], done_w[0], mem_addr_w[0], out_data_w[0], idx_w[0], out_last_w[0], mem_we_w[0]}
            !== {1'b0, 1'b1, 16'h0000, 32'h0000_0000, 4'h0, 1'b0, 1'b0}) begin
            $display("FAIL %s: got valid=%b done=%b addr=%h data=%h idx=%0d last=%b we=%b want 0 1 0000 0 0 0 0",
                     tag, out_valid_w[0], done_w[0], mem_addr_w[0], out_data_w[0], idx_w[0], out_last_w[0], mem_we_w[0]);
        end else begin
            checks_passed++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        check_idle_reset("reset_state");
        checks_total++;
        if ({done_w, out_valid_w} !== 6'b111_000) begin
            $display("FAIL reset_all: got done=%b valid=%b want 111 000", done_w, out_valid_w);
        end else begin
            checks_passed++;
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check_idle_reset("post_reset_idle");
    endtask

    task automatic test_msg20();
        int fi;
        start_msg(0, 16'h0100);
        run_stream(0, 0, 1'b1, 0, fi);
        checks_total++;
        if (fi != 3) begin
            $display("FAIL first_latency: got %0d edges want 3", fi);
        end else begin
            checks_passed++;
        end
    endtask

    task automatic test_pad13();
        int fi;
        start_msg(1, 16'h0100);
        run_stream(1, 0, 1'b1, 0, fi);
    endtask

    task automatic test_pad14();
        int fi;
        start_msg(2, 16'h0100);
        run_stream(2, 0, 1'b1, 0, fi);
    endtask

    task automatic test_stalls();
        int fi;
        start_msg(0, 16'h0100);
        run_stream(0, 5, 1'b1, 0, fi);
    endtask

    task automatic test_abort();
        int fi;
        int waited;
        start_msg(0, 16'h0100);
        run_stream(0, 0, 1'b0, 5, fi);
        // Second start while busy must be ignored.
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        run_stream(0, 0, 1'b0, 5, fi);
        waited = 0;
        while (out_valid_w[0] !== 1'b1 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        checks_total++;
        if (out_valid_w[0] !== 1'b1 || exp_q.size() == 0) begin
            $display("FAIL word10_offer: got valid %b want 1", out_valid_w[0]);
        end else if (out_data_w[0] !== exp_q[0].data) begin
            $display("FAIL word10_offer: got %h want %h", out_data_w[0], exp_q[0].data);
        end else begin
            checks_passed++;
        end
        #1 reset_n = 1'b0;
        #1 check_idle_reset("abort_reset");
        @(negedge clk);
        reset_n = 1'b1;
        exp_q.delete();
        addr_q.delete();
        start_msg(0, 16'h0100);
        run_stream(0, 0, 1'b1, 0, fi);
    endtask

    task automatic test_wrap();
        int fi;
        we_bad = 1'b0;
        start_msg(0, 16'hFFFE);
        run_stream(0, 2, 1'b1, 0, fi);
        checks_total++;
        if (addr_q.size() != 0 || we_bad) begin
            $display("FAIL wrap_reads: got %0d missing reads, we_seen=%b want 0 0", addr_q.size(), we_bad);
        end else begin
            checks_passed++;
        end
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        we_bad        = 1'b0;
        reset_n       = 1'b0;
        start_v       = 3'b000;
        ready_v       = 3'b000;
        for (int i = 0; i < 3; i++) base_v[i] = 16'h0000;
        for (int a = 0; a < 65536; a++) mem[a] = 32'hC0DE_0000 ^ 32'(a);
        for (int i = 0; i < 20; i++) mem[16'h0100 + i] = 32'(i + 1);

        test_reset();
        test_msg20();
        test_pad13();
        test_pad14();
        test_stalls();
        test_abort();
        test_wrap();

        checks_total++;
        if (we_bad) begin
            $display("FAIL mem_we: got 1 want 0");
        end else begin
            checks_passed++;
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
